// File: rtl/adder_result_fifo.sv
// First-word-fall-through result queue for adder_datapath_control output.
// Define ADDER_RESULT_FIFO_OVF_EN to enable the sticky overflow flag.
module adder_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           din,
    input  logic                       irdy,
    input  logic                       rd,
    output logic [WIDTH-1:0]           dout,
    output logic                       ordy,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = rd && !w_empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign w_push  = irdy && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; it is masked from dout while the queue is empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wptr] <= din;
    end

`ifdef ADDER_RESULT_FIFO_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (irdy && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign ordy  = !w_empty;
    assign full  = w_full;
    assign count = r_count;
    assign dout  = w_empty ? '0 : r_mem[r_rptr];

endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo (WIDTH=16, DEPTH=4).
module tb_adder_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             irdy;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             ordy;
    logic             full;
    logic [2:0]       count;
    logic             ovf;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [WIDTH-1:0] sb_q[$];
    logic             m_ovf = 1'b0;

    adder_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .irdy  (irdy),
        .rd    (rd),
        .dout  (dout),
        .ordy  (ordy),
        .full  (full),
        .count (count),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        int unsigned sz;
        sz = sb_q.size();
        check_eq("count", 32'(count), 32'(sz));
        check_eq("ordy",  32'(ordy),  32'(sz != 0));
        check_eq("full",  32'(full),  32'(sz == DEPTH));
        check_eq("ovf",   32'(ovf),   32'(m_ovf));
        check_eq("dout",  32'(dout),  (sz != 0) ? 32'(sb_q[0]) : 32'd0);
    endtask

    // Drive one cycle of stimulus; check pre-edge outputs, then advance the model.
    task automatic step(input logic ir, input logic [WIDTH-1:0] d, input logic r);
        int unsigned sz;
        logic        pop;
        logic [WIDTH-1:0] exp_word;
        irdy = ir;
        din  = d;
        rd   = r;
        #1;
        check_state();
        sz  = sb_q.size();
        pop = r && (sz != 0);
        if (pop) begin
            exp_word = sb_q.pop_front();
            check_eq("pop_data", 32'(dout), 32'(exp_word));
        end
        if (ir && (sz < DEPTH || pop)) sb_q.push_back(d);
`ifdef ADDER_RESULT_FIFO_OVF_EN
        if (ir && sz == DEPTH && !pop) m_ovf = 1'b1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned cycles, input logic ir, input logic r);
        reset = 1'b1;
        irdy  = ir;
        rd    = r;
        din   = 16'hDEAD;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        irdy  = 1'b0;
        rd    = 1'b0;
        sb_q.delete();
        m_ovf = 1'b0;
        check_state();
    endtask

    initial begin
        reset = 1'b1;
        irdy  = 1'b0;
        rd    = 1'b0;
        din   = '0;

        do_reset(5, 1'b0, 1'b0);

        // Single push, latency-1 visibility, then single pop.
        step(1'b1, 16'h0001, 1'b0);
        check_eq("lat1_dout", 32'(dout), 32'h0001);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        // rd while empty must be ignored.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Fill to full, overflow push, drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(i * 16'h0010), 1'b0);
        step(1'b1, 16'h0050, 1'b0);
        step(1'b0, '0, 1'b0);
        check_eq("ovf_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Push+pop while full is accepted.
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h00A0 + i), 1'b0);
        step(1'b1, 16'h00AA, 1'b1);
        check_eq("full_hold", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Streaming push/pop, pointers wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h0100 + i), 1'b1);
        check_eq("stream_cnt", 32'(count), 32'd1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Reset takes priority over concurrent push/pop.
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0200 + i), 1'b0);
        do_reset(1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0);

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/adder_result_fifo.md
ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

Interface
REQ-001 Parameter WIDTH, default 16, data width of stored results; SHALL match adder_datapath_control dout width.
REQ-002 Parameter DEPTH, default 4, number of result entries; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 din  input  WIDTH  result word from adder_datapath_control dout.
REQ-006 irdy  input  1  result-valid strobe from adder_datapath_control ordy; one push per cycle asserted.
REQ-007 rd  input  1  consumer pop request.
REQ-008 dout  output  WIDTH  head-of-queue word (first-word-fall-through).
REQ-009 ordy  output  1  queue non-empty; dout valid.
REQ-010 full  output  1  queue holds DEPTH entries.
REQ-011 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 ovf  output  1  overflow flag (see Configuration).

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries with write pointer, read pointer and occupancy counter.
REQ-014 Push SHALL occur when irdy=1 and (full=0 or pop occurs in the same cycle).
REQ-015 Pop SHALL occur when rd=1 and ordy=1; rd while empty SHALL be ignored, no state change.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0 without gaps.
REQ-017 Push only: count +1; pop only: count -1; push and pop together: count unchanged, both pointers advance.
REQ-018 Push to empty queue SHALL make ordy=1 and dout=pushed word on the cycle after the push edge (latency 1).
REQ-019 Simultaneous push and pop while count=1 SHALL leave ordy=1 and dout=new word next cycle.
REQ-020 Simultaneous push and pop while full SHALL accept the push; full SHALL remain 1.
REQ-021 Push while full without pop SHALL discard din; stored contents, pointers, count unchanged.
REQ-022 dout SHALL be driven from the entry at the read pointer; when ordy=0 dout SHALL be 0.
REQ-023 full SHALL equal (count==DEPTH); ordy SHALL equal (count!=0); both derived from registered state only.
REQ-024 Outputs SHALL never depend combinationally on rd or irdy.

Reset
REQ-025 reset=1 at a rising edge SHALL clear pointers, count and ovf; after that edge ordy=0, full=0, count=0, dout=0, ovf=0.
REQ-026 reset SHALL take priority over simultaneous push/pop; all queued data SHALL be discarded, mid-operation included.
REQ-027 Storage array contents need not be cleared; they SHALL be unobservable while ordy=0.

Configuration
REQ-028 Macro ADDER_RESULT_FIFO_OVF_EN SHALL control overflow tracking.
REQ-029 Defined: ovf SHALL set to 1 on the cycle after any discarded push (REQ-021) and stay 1 (sticky) until reset.
REQ-030 Not defined: ovf SHALL be constant 0, no overflow register synthesized; all other behaviour identical.

Verification
REQ-031 Reset held 5 cycles, then released -> ordy=0, full=0, count=0, dout=0, ovf=0.
REQ-032 Push 0x0001 one cycle, rd=0 -> next cycle ordy=1, dout=0x0001, count=1; rd=1 one cycle -> ordy=0, count=0.
REQ-033 Push 0x0010,0x0020,0x0030,0x0040 consecutive, then 0x0050 -> full=1, count=4, 0x0050 dropped; pops return 0x0010..0x0040 in order; ovf=1 with macro, 0 without.
REQ-034 Fill to 4, then push 0x00AA with rd=1 same cycle -> full stays 1, 0x00AA emerges as 4th subsequent pop, ovf unchanged.
REQ-035 Push/pop 10 words 0x0100..0x0109 continuously with rd=1 -> pointers wrap, count stays 1 after first cycle, output order preserved.
REQ-036 Fill 3 entries, assert reset concurrently with irdy=1 and rd=1 -> next cycle count=0, ordy=0, ovf=0.
